mod_down_timer: RTL and testbench

MOD_DOWN_TIMER -- requirements
Module: mod_down_timer

---
 rtl/timer_pkg.sv | 30 +++
 rtl/down_counter_core.sv | 51 +++++
 rtl/mod_down_timer.sv | 121 ++++++++++++
 tb/tb_mod_down_timer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared definitions for the down-timer family: the 2-bit
//                controller state encoding and the load saturation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Widest counter any timer stage may be built with.
    localparam int c_max_width = 16;

    // Controller states; the encoding is fixed so it can be observed externally.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } timer_state_e;

    // Clamp a requested load value so the counter never exceeds its reload value.
    function automatic logic [c_max_width-1:0] sat_to_max(
        input logic [c_max_width-1:0] value,
        input logic [c_max_width-1:0] max_value
    );
        return (value > max_value) ? max_value : value;
    endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/down_counter_core.sv
`default_nettype none
// ============================================================================
//  Module      : down_counter_core
//  Description : Counter datapath for one timer stage: saturating load,
//                reload to MAX_VALUE, and a decrement that stops at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module down_counter_core
    import timer_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int MAX_VALUE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    input  logic             reload_en,
    input  logic             dec_en,
    output logic [WIDTH-1:0] count,
    output logic             is_zero
);

    localparam logic [WIDTH-1:0] c_max_value = WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_load_sat;

    // Oversized load requests are clamped to the reload value.
    always_comb begin
        w_load_sat = WIDTH'(sat_to_max(c_max_width'(load_value), c_max_width'(MAX_VALUE)));
    end

    // Count register: reset > load > reload > decrement; zero never underflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= c_max_value;
        end else if (load_en) begin
            r_count <= w_load_sat;
        end else if (reload_en) begin
            r_count <= c_max_value;
        end else if (dec_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign count   = r_count;
    assign is_zero = (r_count == '0);

endmodule : down_counter_core
`default_nettype wire

// File: rtl/mod_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mod_down_timer
//  Description : Cascadable down-timer stage. Controller FSM (IDLE, RUN,
//                PAUSED, EXPIRED) driving a down_counter_core datapath, with a
//                combinational borrow_out for chaining stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int MAX_VALUE   = 3,
    parameter int AUTO_RELOAD = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] q_bus,
    output logic             borrow_out,
    output logic             expired,
    output logic             running
);

    timer_state_e r_state;
    timer_state_e w_next_state;
    logic         w_dec;
    logic         w_reload;
    logic         w_is_zero;
    logic         r_expired;
    logic         r_running;

    // State register plus registered status flags that track the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_expired <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_expired <= (w_next_state == ST_EXPIRED);
            r_running <= (w_next_state == ST_RUN);
        end
    end

    // Next state and datapath controls; load overrides pause, pause overrides start.
    always_comb begin
        w_next_state = r_state;
        w_dec        = 1'b0;
        w_reload     = 1'b0;
        if (load) begin
            // A load clears an expiry but otherwise leaves the state alone.
            if (r_state == ST_EXPIRED) begin
                w_next_state = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!pause && start) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        w_next_state = ST_PAUSED;
                    end else if (borrow_in) begin
                        if (!w_is_zero) begin
                            w_dec = 1'b1;
                        end else if (AUTO_RELOAD != 0) begin
                            w_reload = 1'b1;
                        end else begin
                            w_next_state = ST_EXPIRED;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause && start) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    if (!pause && start) begin
                        w_reload     = 1'b1;
                        w_next_state = ST_RUN;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    down_counter_core #(
        .WIDTH     (WIDTH),
        .MAX_VALUE (MAX_VALUE)
    ) u_core (
        .clk        (clock),
        .rst        (reset),
        .load_en    (load),
        .load_value (load_value),
        .reload_en  (w_reload),
        .dec_en     (w_dec),
        .count      (q_bus),
        .is_zero    (w_is_zero)
    );

    // Terminal-count tick for the next stage; suppressed by reset and load.
    always_comb begin
        borrow_out = borrow_in && (r_state == ST_RUN) && w_is_zero && !load && !reset;
    end

    assign expired = r_expired;
    assign running = r_running;

endmodule : mod_down_timer
`default_nettype wire

// File: tb/tb_mod_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_down_timer
//  Description : Directed self-checking bench for mod_down_timer covering
//                auto-reload, expiry, pause, saturating load, reset and a
//                two-stage cascade.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_down_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic rst;

    // Instance A: WIDTH=2, MAX=3, auto-reload
    logic       a_start, a_pause, a_load, a_bin;
    logic [1:0] a_lv, a_q;
    logic       a_bo, a_exp, a_run;
    // Instance B: WIDTH=2, MAX=3, halt at zero
    logic       b_start, b_pause, b_load, b_bin;
    logic [1:0] b_lv, b_q;
    logic       b_bo, b_exp, b_run;
    // Instance C: WIDTH=3, MAX=5, auto-reload
    logic       c_start, c_pause, c_load, c_bin;
    logic [2:0] c_lv, c_q;
    logic       c_bo, c_exp, c_run;
    // Cascade: lo stage feeds hi stage
    logic       k_start, k_tick;
    logic [1:0] lo_q, hi_q;
    logic       lo_bo, hi_bo, lo_exp, hi_exp, lo_run, hi_run;

    mod_down_timer #(.WIDTH(2), .MAX_VALUE(3), .AUTO_RELOAD(1)) dut_a (
        .clock(clk), .reset(rst), .start(a_start), .pause(a_pause), .load(a_load),
        .load_value(a_lv), .borrow_in(a_bin), .q_bus(a_q), .borrow_out(a_bo),
        .expired(a_exp), .running(a_run));

    mod_down_timer #(.WIDTH(2), .MAX_VALUE(3), .AUTO_RELOAD(0)) dut_b (
        .clock(clk), .reset(rst), .start(b_start), .pause(b_pause), .load(b_load),
        .load_value(b_lv), .borrow_in(b_bin), .q_bus(b_q), .borrow_out(b_bo),
        .expired(b_exp), .running(b_run));

    mod_down_timer #(.WIDTH(3), .MAX_VALUE(5), .AUTO_RELOAD(1)) dut_c (
        .clock(clk), .reset(rst), .start(c_start), .pause(c_pause), .load(c_load),
        .load_value(c_lv), .borrow_in(c_bin), .q_bus(c_q), .borrow_out(c_bo),
        .expired(c_exp), .running(c_run));

    mod_down_timer #(.WIDTH(2), .MAX_VALUE(3), .AUTO_RELOAD(1)) dut_lo (
        .clock(clk), .reset(rst), .start(k_start), .pause(1'b0), .load(1'b0),
        .load_value(2'd0), .borrow_in(k_tick), .q_bus(lo_q), .borrow_out(lo_bo),
        .expired(lo_exp), .running(lo_run));

    mod_down_timer #(.WIDTH(2), .MAX_VALUE(3), .AUTO_RELOAD(1)) dut_hi (
        .clock(clk), .reset(rst), .start(k_start), .pause(1'b0), .load(1'b0),
        .load_value(2'd0), .borrow_in(lo_bo), .q_bus(hi_q), .borrow_out(hi_bo),
        .expired(hi_exp), .running(hi_run));

    task automatic idle_inputs();
        a_start = 0; a_pause = 0; a_load = 0; a_bin = 0; a_lv = '0;
        b_start = 0; b_pause = 0; b_load = 0; b_bin = 0; b_lv = '0;
        c_start = 0; c_pause = 0; c_load = 0; c_bin = 0; c_lv = '0;
        k_start = 0; k_tick = 0;
    endtask

    // One clock edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        a_bin = 1; b_bin = 1; a_start = 1;
        #1;
        total++;
        if (a_q !== 2'd3 || a_exp !== 1'b0 || a_run !== 1'b0) begin
            bad++; $display("FAIL reset_state: q=%0d exp=%b run=%b, want q=3 exp=0 run=0", a_q, a_exp, a_run);
        end
        total++;
        if (a_bo !== 1'b0 || b_bo !== 1'b0) begin
            bad++; $display("FAIL reset_borrow: a_bo=%b b_bo=%b, want 0", a_bo, b_bo);
        end
        total++;
        if (c_q !== 3'd5) begin
            bad++; $display("FAIL reset_c: q=%0d, want 5", c_q);
        end
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_autoreload();
        logic [1:0] exp_q [6] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
        do_reset();
        a_start = 1; step(); a_start = 0;
        total++;
        if (a_run !== 1'b1) begin
            bad++; $display("FAIL start_run: running=%b, want 1", a_run);
        end
        for (int i = 0; i < 5; i++) begin
            a_bin = 1;
            #1;
            total++;
            if (a_q !== exp_q[i] || a_bo !== (i == 3)) begin
                bad++; $display("FAIL autoreload[%0d]: q=%0d bo=%b, want q=%0d bo=%b", i, a_q, a_bo, exp_q[i], (i == 3));
            end
            step();
        end
        a_bin = 0;
        #1;
        total++;
        if (a_q !== exp_q[5] || a_run !== 1'b1) begin
            bad++; $display("FAIL autoreload_end: q=%0d run=%b, want q=2 run=1", a_q, a_run);
        end
    endtask

    task automatic test_expire();
        do_reset();
        b_start = 1; step(); b_start = 0;
        b_bin = 1;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (b_q !== 2'd0 || b_exp !== 1'b1 || b_run !== 1'b0) begin
            bad++; $display("FAIL expire: q=%0d exp=%b run=%b, want q=0 exp=1 run=0", b_q, b_exp, b_run);
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (b_bo !== 1'b0 || b_q !== 2'd0) begin
                bad++; $display("FAIL expire_hold[%0d]: q=%0d bo=%b, want q=0 bo=0", i, b_q, b_bo);
            end
            step();
        end
        b_bin = 0; b_start = 1; step(); b_start = 0;
        total++;
        if (b_q !== 2'd3 || b_run !== 1'b1 || b_exp !== 1'b0) begin
            bad++; $display("FAIL expire_restart: q=%0d run=%b exp=%b, want q=3 run=1 exp=0", b_q, b_run, b_exp);
        end
    endtask

    task automatic test_pause();
        do_reset();
        a_start = 1; step(); a_start = 0;
        a_bin = 1; step();
        a_pause = 1; step(); a_pause = 0;
        total++;
        if (a_q !== 2'd2 || a_run !== 1'b0) begin
            bad++; $display("FAIL pause_enter: q=%0d run=%b, want q=2 run=0", a_q, a_run);
        end
        for (int i = 0; i < 3; i++) step();
        total++;
        if (a_q !== 2'd2 || a_bo !== 1'b0) begin
            bad++; $display("FAIL pause_ticks: q=%0d bo=%b, want q=2 bo=0", a_q, a_bo);
        end
        a_bin = 0; a_pause = 1; a_start = 1; step(); a_pause = 0;
        total++;
        if (a_run !== 1'b0) begin
            bad++; $display("FAIL pause_start_both: running=%b, want 0", a_run);
        end
        step(); a_start = 0;
        total++;
        if (a_run !== 1'b1 || a_q !== 2'd2) begin
            bad++; $display("FAIL pause_resume: run=%b q=%0d, want run=1 q=2", a_run, a_q);
        end
        a_bin = 1; step(); a_bin = 0;
        total++;
        if (a_q !== 2'd1) begin
            bad++; $display("FAIL pause_tick_after: q=%0d, want 1", a_q);
        end
    endtask

    task automatic test_load();
        do_reset();
        c_load = 1; c_lv = 3'd7; step(); c_load = 0;
        total++;
        if (c_q !== 3'd5 || c_run !== 1'b0) begin
            bad++; $display("FAIL load_sat: q=%0d run=%b, want q=5 run=0", c_q, c_run);
        end
        c_start = 1; step(); c_start = 0;
        c_load = 1; c_lv = 3'd2; c_bin = 1;
        #1;
        total++;
        if (c_bo !== 1'b0) begin
            bad++; $display("FAIL load_borrow: bo=%b, want 0", c_bo);
        end
        step(); c_load = 0;
        total++;
        if (c_q !== 3'd2 || c_run !== 1'b1) begin
            bad++; $display("FAIL load_run: q=%0d run=%b, want q=2 run=1", c_q, c_run);
        end
        step(); c_bin = 0;
        total++;
        if (c_q !== 3'd1) begin
            bad++; $display("FAIL load_then_tick: q=%0d, want 1", c_q);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        b_start = 1; step(); b_start = 0;
        b_bin = 1;
        for (int i = 0; i < 4; i++) step();
        a_start = 1; step(); a_start = 0;
        a_bin = 1; step(); step();
        total++;
        if (b_exp !== 1'b1 || a_q !== 2'd1) begin
            bad++; $display("FAIL reset_mid_setup: b_exp=%b a_q=%0d, want 1 and 1", b_exp, a_q);
        end
        rst = 1; b_start = 1; a_start = 1;
        #1;
        total++;
        if (a_bo !== 1'b0 || b_bo !== 1'b0) begin
            bad++; $display("FAIL reset_mid_bo: a_bo=%b b_bo=%b, want 0", a_bo, b_bo);
        end
        step(); rst = 0; idle_inputs();
        #1;
        total++;
        if (b_q !== 2'd3 || b_exp !== 1'b0 || b_run !== 1'b0) begin
            bad++; $display("FAIL reset_from_expired: q=%0d exp=%b run=%b, want q=3 exp=0 run=0", b_q, b_exp, b_run);
        end
        total++;
        if (a_q !== 2'd3 || a_exp !== 1'b0 || a_run !== 1'b0 || a_bo !== 1'b0) begin
            bad++; $display("FAIL reset_midcount: q=%0d exp=%b run=%b bo=%b, want q=3 exp=0 run=0 bo=0", a_q, a_exp, a_run, a_bo);
        end
    endtask

    task automatic test_cascade();
        logic [3:0] want;
        do_reset();
        k_start = 1; step(); k_start = 0;
        k_tick = 1;
        for (int i = 0; i < 18; i++) begin
            want = 4'(15 - i);
            #1;
            total++;
            if ({hi_q, lo_q} !== want || hi_bo !== (want == 4'd0)) begin
                bad++; $display("FAIL cascade[%0d]: count=%0d hi_bo=%b, want count=%0d hi_bo=%b", i, {hi_q, lo_q}, hi_bo, want, (want == 4'd0));
            end
            step();
        end
        k_tick = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_autoreload();
        test_expire();
        test_pause();
        test_load();
        test_reset_mid();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mod_down_timer
`default_nettype wire
